// File: rtl/prog_loader.sv
// UART boot loader: receives a word count and program words,
// writes them to program memory, then releases the core.
module prog_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int MEM_WORDS    = 129
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_rst,
  output logic        done,
  output logic        error
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(MEM_WORDS + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [31:0]   MAX_N     = 32'(MEM_WORDS);

  typedef enum logic [1:0] {
    R_IDLE, R_START, R_DATA, R_STOP
  } rx_st_e;

  typedef enum logic [2:0] {
    LEN, DATA, WRITE, DONE, ERR
  } ld_st_e;

  logic          rx_s1_q, rx_s2_q, rx_s3_q;
  rx_st_e        rs_q, rs_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          byte_valid;

  ld_st_e        st_q, st_d;
  logic [1:0]    lane_q, lane_d;
  logic [31:0]   len_q, len_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   n_full;
  logic [IW-1:0] idx_inc;

  // rx synchronizer plus one delayed copy for falling-edge detect
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
      rx_s3_q <= 1'b1;
    end else begin
      rx_s1_q <= rx;
      rx_s2_q <= rx_s1_q;
      rx_s3_q <= rx_s2_q;
    end
  end

  // receiver state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rs_q  <= R_IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      sh_q  <= '0;
    end else begin
      rs_q  <= rs_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      sh_q  <= sh_d;
    end
  end

  // receiver next state: mid-bit sampling, glitch and framing rejection
  always_comb begin
    rs_d       = rs_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    sh_d       = sh_q;
    byte_valid = 1'b0;
    unique case (rs_q)
      R_IDLE: begin
        if (rx_s3_q && !rx_s2_q) begin
          rs_d  = R_START;
          cnt_d = '0;
        end
      end
      R_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          bit_d = '0;
          rs_d  = rx_s2_q ? R_IDLE : R_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      R_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          sh_d  = {rx_s2_q, sh_q[7:1]};
          if (bit_q == 3'd7) begin
            rs_d = R_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      R_STOP: begin
        if (cnt_q == BIT_LAST) begin
          rs_d       = R_IDLE;
          byte_valid = rx_s2_q;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: rs_d = R_IDLE;
    endcase
  end

  // loader state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q    <= LEN;
      lane_q  <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      addr_q  <= '0;
    end else begin
      st_q    <= st_d;
      lane_q  <= lane_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      addr_q  <= addr_d;
    end
  end

  assign n_full  = {sh_q, len_q[31:8]};
  assign idx_inc = idx_q + IW'(1);

  // loader next state: count, word assembly, write, terminal states
  always_comb begin
    st_d    = st_q;
    lane_d  = lane_q;
    len_d   = len_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    addr_d  = addr_q;
    unique case (st_q)
      LEN: begin
        if (byte_valid) begin
          len_d  = n_full;
          lane_d = lane_q + 2'd1;
          if (lane_q == 2'd3) begin
            lane_d = '0;
            if (n_full == 32'd0) begin
              st_d = DONE;
            end else if (n_full > MAX_N) begin
              st_d = ERR;
            end else begin
              st_d  = DATA;
              idx_d = '0;
            end
          end
        end
      end
      DATA: begin
        if (byte_valid) begin
          unique case (lane_q)
            2'd0: wdata_d[7:0]   = sh_q;
            2'd1: wdata_d[15:8]  = sh_q;
            2'd2: wdata_d[23:16] = sh_q;
            2'd3: wdata_d[31:24] = sh_q;
          endcase
          lane_d = lane_q + 2'd1;
          if (lane_q == 2'd3) begin
            st_d   = WRITE;
            addr_d = {{(30 - IW){1'b0}}, idx_q, 2'b00};
          end
        end
      end
      WRITE: begin
        idx_d  = idx_inc;
        lane_d = '0;
        st_d   = (idx_inc == len_q[IW-1:0]) ? DONE : DATA;
      end
      DONE: ;
      ERR: ;
      default: st_d = LEN;
    endcase
  end

  assign mem_we    = (st_q == WRITE);
  assign mem_be    = mem_we ? 4'hF : 4'h0;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign cpu_rst   = (st_q != DONE);
  assign done      = (st_q == DONE);
  assign error     = (st_q == ERR);

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader with a write scoreboard.
// Expected writes are queued as bytes are sent, checked per strobe.
module tb_prog_loader;

  localparam int CPB = 4;
  localparam int MW  = 129;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx = 1'b1;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_rst;
  logic        done;
  logic        error;

  int vec = 0;
  int miss = 0;
  int cyc = 0;
  int wcnt = 0;
  int last_we_cyc = -10;
  int done_cyc = -1;
  logic done_prev = 1'b0;
  logic [31:0] last_addr = '0;
  int w0;
  wr_t q[$];

  prog_loader #(
    .CLKS_PER_BIT(CPB),
    .MEM_WORDS(MW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rx(rx),
    .mem_we(mem_we),
    .mem_be(mem_be),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .cpu_rst(cpu_rst),
    .done(done),
    .error(error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // one clock, sampled at the falling edge; scoreboards any write
  task automatic tick();
    wr_t e;
    @(negedge clk);
    cyc++;
    if (done === 1'b1 && done_prev !== 1'b1) done_cyc = cyc;
    done_prev = done;
    if (mem_we === 1'b1) begin
      wcnt++;
      last_we_cyc = cyc;
      last_addr = mem_addr;
      if (q.size() == 0) begin
        chk("unexpected_we", 32'(mem_we), 32'd0);
      end else begin
        e = q.pop_front();
        chk("wr_addr", mem_addr, e.a);
        chk("wr_data", mem_wdata, e.d);
        chk("wr_be", 32'(mem_be), 32'hF);
      end
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    ticks(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      ticks(CPB);
    end
    rx = stop;
    ticks(CPB);
    rx = 1'b1;
    ticks(CPB);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
  endtask

  task automatic expect_wr(input logic [31:0] a, input logic [31:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    q.push_back(e);
  endtask

  task automatic do_reset();
    rx = 1'b1;
    reset = 1'b1;
    ticks(3);
    q.delete();
    reset = 1'b0;
    done_prev = 1'b0;
    done_cyc = -1;
    ticks(4);
  endtask

  task automatic chk_rst_vals(input string p);
    chk({p, "_we"}, 32'(mem_we), 32'd0);
    chk({p, "_be"}, 32'(mem_be), 32'd0);
    chk({p, "_addr"}, mem_addr, 32'd0);
    chk({p, "_wdata"}, mem_wdata, 32'd0);
    chk({p, "_cpu_rst"}, 32'(cpu_rst), 32'd1);
    chk({p, "_done"}, 32'(done), 32'd0);
    chk({p, "_error"}, 32'(error), 32'd0);
  endtask

  task automatic wait_done(input string tag, input int bound);
    int n = 0;
    while (done !== 1'b1 && n < bound) begin
      tick();
      n++;
    end
    chk(tag, 32'(done), 32'd1);
  endtask

  task automatic two_word_load(input string p);
    expect_wr(32'h0, 32'hDEADBEEF);
    expect_wr(32'h4, 32'h12345678);
    w0 = wcnt;
    send_word(32'd2);
    send_word(32'hDEADBEEF);
    send_word(32'h12345678);
    wait_done({p, "_done"}, 200);
    chk({p, "_cpu_rst"}, 32'(cpu_rst), 32'd0);
    chk({p, "_nwr"}, 32'(wcnt - w0), 32'd2);
    chk({p, "_q_empty"}, 32'(q.size()), 32'd0);
    chk({p, "_done_lat"}, 32'(done_cyc), 32'(last_we_cyc + 1));
  endtask

  initial begin
    logic [31:0] d;

    // reset state and quiet line
    do_reset();
    chk_rst_vals("rst");
    w0 = wcnt;
    ticks(200);
    chk("rst_nowr", 32'(wcnt - w0), 32'd0);
    chk("rst_cpu_rst_hold", 32'(cpu_rst), 32'd1);

    // two-word load
    two_word_load("s2");

    // post-done traffic
    w0 = wcnt;
    for (int i = 0; i < 8; i++) send_byte(8'(8'hA0 + i), 1'b1);
    chk("s6_nowr", 32'(wcnt - w0), 32'd0);
    chk("s6_done", 32'(done), 32'd1);
    chk("s6_cpu_rst", 32'(cpu_rst), 32'd0);

    // reset during the 2nd data byte
    do_reset();
    send_word(32'd2);
    send_byte(8'hEF, 1'b1);
    rx = 1'b0;
    ticks(CPB + 2);
    #2 reset = 1'b1;
    #1 chk_rst_vals("s5_async");
    q.delete();
    rx = 1'b1;
    ticks(3);
    reset = 1'b0;
    done_prev = 1'b0;
    done_cyc = -1;
    ticks(10);
    two_word_load("s5_replay");

    // zero count
    do_reset();
    w0 = wcnt;
    send_word(32'd0);
    wait_done("s3_zero_done", 100);
    chk("s3_zero_cpu_rst", 32'(cpu_rst), 32'd0);
    chk("s3_zero_nwr", 32'(wcnt - w0), 32'd0);

    // overflow count
    do_reset();
    w0 = wcnt;
    send_word(32'd130);
    ticks(20);
    chk("s3_ovf_error", 32'(error), 32'd1);
    chk("s3_ovf_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("s3_ovf_done", 32'(done), 32'd0);
    send_word(32'h11223344);
    chk("s3_ovf_nwr", 32'(wcnt - w0), 32'd0);

    // all-ones count is compared in full
    do_reset();
    send_word(32'hFFFF_FFFF);
    ticks(20);
    chk("s3_ff_error", 32'(error), 32'd1);

    // full capacity
    do_reset();
    w0 = wcnt;
    send_word(32'(MW));
    for (int i = 0; i < MW; i++) begin
      d = $urandom;
      expect_wr(32'(i * 4), d);
      send_word(d);
    end
    wait_done("s3_full_done", 200);
    chk("s3_full_nwr", 32'(wcnt - w0), 32'(MW));
    chk("s3_full_last_addr", last_addr, 32'h200);
    chk("s3_full_q_empty", 32'(q.size()), 32'd0);

    // glitch, then framing error byte
    do_reset();
    rx = 1'b0;
    tick();
    rx = 1'b1;
    ticks(30);
    w0 = wcnt;
    send_word(32'd1);
    send_byte(8'h11, 1'b0);
    expect_wr(32'h0, 32'h44332211);
    send_word(32'h44332211);
    wait_done("s4_done", 200);
    chk("s4_nwr", 32'(wcnt - w0), 32'd1);
    chk("s4_q_empty", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

UART boot loader that fills program memory before the core starts. It receives a word count and program words over a serial line, assembles bytes into 32-bit words and drives the program-memory write port (we, be, addr, data_in) one word per write strobe. It holds the core in reset until the image is fully written, then releases it. It sits directly upstream of the program memory's write port and shares that port with nothing else while `cpu_rst` is high.

## Interface

**Parameters**
- `CLKS_PER_BIT`, default 868: clock cycles per UART bit (100 MHz / 115200 baud). Legal range is 4 or more.
- `MEM_WORDS`, default 129: capacity of the program memory in 32-bit words.

**Ports**
- `clk`, input, 1: single clock. All state is on its rising edge.
- `reset`, input, 1: asynchronous, active-high. Returns every register to its reset value immediately.
- `rx`, input, 1: UART receive line. Idle-high, 8N1, LSB first. Asynchronous to `clk`.
- `mem_we`, output, 1: program-memory write enable, a one-cycle pulse per word.
- `mem_be`, output, 4: byte enables. Equal to 4'hF while `mem_we` is high, otherwise 4'h0.
- `mem_addr`, output, 32: byte address, word-aligned (bits [1:0] are always 0).
- `mem_wdata`, output, 32: assembled word.
- `cpu_rst`, output, 1: core reset. High from reset until the load completes.
- `done`, output, 1: sticky. Set when the load completes.
- `error`, output, 1: sticky. Set when the word count exceeds capacity.

## Operation

**UART receiver**
- `rx` passes through a 2-flop synchronizer before use.
- A start bit is detected as a high-to-low transition on the synchronized line while the receiver is idle.
- The receiver re-samples the start bit at `CLKS_PER_BIT/2`. If the line is high there, the start is a glitch and the receiver returns to idle.
- It then samples 8 data bits, LSB first, each `CLKS_PER_BIT` cycles apart, followed by the stop bit.
- Stop bit = 1: a one-cycle internal `byte_valid` pulse is produced with the byte.
- Stop bit = 0 (framing error): the byte is dropped and no pulse is produced.

**Loader FSM.** States are `LEN`, `DATA`, `WRITE`, `DONE`, `ERR`. Reset enters `LEN`.
- **LEN**
  - Collects 4 bytes, little-endian, into a 32-bit count N.
  - On the 4th byte:
    - N == 0 goes to `DONE`.
    - N > `MEM_WORDS` goes to `ERR`.
    - Otherwise it goes to `DATA`, with the word index cleared to 0.
- **DATA**
  - Collects 4 bytes, little-endian, into `mem_wdata` (first byte goes to [7:0]).
  - The 4th byte moves the FSM to `WRITE`.
- **WRITE**
  - Lasts exactly one cycle. `mem_we`=1, `mem_be`=4'hF, `mem_addr` = index×4.
  - Next cycle the index increments. If the new index == N the FSM goes to `DONE`, otherwise to `DATA`.
- **DONE**
  - `cpu_rst`=0 and `done`=1.
  - Terminal state. Further `rx` traffic is ignored and the loader never writes again until `reset`.
- **ERR**
  - `error`=1 and `cpu_rst` stays 1.
  - Terminal until `reset`. No writes occur.

**Byte counter.** A 2-bit counter selects the byte lane. It is cleared on every state entry into `LEN` or `DATA`.

**Outputs**
- `mem_addr` and `mem_wdata` stay stable from the `WRITE` cycle until the next byte arrives.
- `mem_addr` outside `WRITE` is don't-care but must still be word-aligned.

## Timing

**Reset values**
- `mem_we`=0, `mem_be`=0, `mem_addr`=0, `mem_wdata`=0.
- `cpu_rst`=1, `done`=0, `error`=0.
- FSM=`LEN`, receiver idle.

**Latencies**
- `byte_valid` fires at the stop-bit sample point. That is about 9.5×`CLKS_PER_BIT` + 2 cycles after the falling `rx` edge, the +2 coming from the synchronizer.
- `mem_we` is asserted on the cycle after the `byte_valid` of the 4th data byte.
- `cpu_rst` falls, and `done` rises, 1 cycle after the last `WRITE` cycle. For N=0 this happens 1 cycle after the 4th count byte.

**Memory-port contract.** The program memory captures on the same `clk` edge that ends the `WRITE` cycle. No more than one write occurs per 4 received bytes.

**Boundary cases**
- N == `MEM_WORDS` is legal. The last address is (`MEM_WORDS`−1)×4.
- N == `MEM_WORDS`+1 goes to `ERR`.
- Count bytes above bit 7 of the index width are still compared, so a count of 32'hFFFF_FFFF goes to `ERR`.
- A framing-error byte is not counted. A subsequent good byte fills the same lane.
- `reset` asserted mid-load (in any state, including mid-bit or during `WRITE`):
  - Outputs return to reset values asynchronously.
  - A write in progress on that edge is aborted, with `mem_we` low.
  - Loading restarts from `LEN`.
- `rx` held low continuously produces at most one framing-error frame and then no further starts until `rx` returns high.

## Test plan

All scenarios use `CLKS_PER_BIT`=4 and `MEM_WORDS`=129.

1. **Reset state.** Assert `reset` with `rx`=1, then release → all outputs at their reset values, `cpu_rst`=1, no `mem_we` for 200 cycles.
2. **Two-word load.** Send bytes 02 00 00 00, EF BE AD DE, 78 56 34 12 → two `mem_we` pulses:
   - addr 0x0, data 0xDEADBEEF, be 4'hF;
   - addr 0x4, data 0x12345678.
   - `done`=1 and `cpu_rst`=0 one cycle after the 2nd pulse.
3. **Zero and overflow counts.**
   - Count 00 00 00 00 → `done`=1 and `cpu_rst`=0 with zero writes.
   - After `reset`, count 82 00 00 00 (130) → `error`=1, `cpu_rst`=1, no writes.
   - After `reset`, count 81 00 00 00 (129) followed by 516 data bytes → the last write is at addr 0x200 and `done`=1.
4. **Framing error.** Count 1, then byte 0x11 with stop bit = 0, then 11 22 33 44 → exactly one write, data 0x44332211.
   - Also check a 1-cycle low glitch on `rx`: no byte is received.
5. **Reset mid-load.** Assert `reset` during the 2nd data byte of scenario 2 → outputs return to reset values immediately. Replaying the full stream then reproduces scenario 2 exactly.
6. **Post-done traffic.** After scenario 2, send 8 more bytes → no `mem_we` pulse, and `done` and `cpu_rst` are unchanged.
